// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: EX/MEM register, data-memory req/ack sequencing,
// MEM/WB register, EX/MEM forwarding and a sticky misalignment/timeout error flag.
module mem_access_stage #(
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned REG_W          = 4,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid,
  input  logic [DATA_W-1:0] ex_result,
  input  logic [DATA_W-1:0] ex_out_b,
  input  logic [REG_W-1:0]  ex_rd,
  input  logic              ex_mem_read,
  input  logic              ex_mem_write,
  input  logic              ex_reg_write,
  input  logic              flush,
  output logic              stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              wb_valid,
  output logic              wb_reg_write,
  output logic [REG_W-1:0]  wb_rd,
  output logic [DATA_W-1:0] wb_data,
  output logic              fwd_valid,
  output logic [REG_W-1:0]  fwd_rd,
  output logic [DATA_W-1:0] fwd_data,
  output logic              mem_err
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_t;

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] result;
    logic [DATA_W-1:0] b;
    logic [REG_W-1:0]  rd;
    logic              mem_read;
    logic              mem_write;
    logic              reg_write;
  } stage_t;

  state_t            r_state;
  stage_t            r_s;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_mem_req;
  logic              r_mem_we;
  logic [DATA_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic              r_wb_valid;
  logic              r_wb_reg_write;
  logic [REG_W-1:0]  r_wb_rd;
  logic [DATA_W-1:0] r_wb_data;
  logic              r_mem_err;

  stage_t            w_cap;
  logic              w_cap_mem;
  logic              w_ack;
  logic              w_s_is_mem;

  // Incoming instruction as it would be captured; a load+store is treated as a load
  always_comb begin
    w_cap           = '0;
    w_cap.valid     = ex_valid & ~flush;
    w_cap.result    = ex_result;
    w_cap.b         = ex_out_b;
    w_cap.rd        = ex_rd;
    w_cap.mem_read  = ex_mem_read;
    w_cap.mem_write = ex_mem_write & ~ex_mem_read;
    w_cap.reg_write = ex_reg_write;
  end

  assign w_cap_mem  = w_cap.valid & (w_cap.mem_read | w_cap.mem_write) &
                      (ex_result[1:0] == 2'b00);
  assign w_s_is_mem = r_s.mem_read | r_s.mem_write;

  // Ack only counts while a request is actually on the bus
  assign w_ack = r_mem_req & mem_ack;
  assign stall = (r_state == ST_ACCESS) & ~w_ack;

  assign fwd_valid = r_s.valid & r_s.reg_write & ~r_s.mem_read;
  assign fwd_rd    = r_s.rd;
  assign fwd_data  = r_s.result;

  assign mem_req      = r_mem_req;
  assign mem_we       = r_mem_we;
  assign mem_addr     = r_mem_addr;
  assign mem_wdata    = r_mem_wdata;
  assign wb_valid     = r_wb_valid;
  assign wb_reg_write = r_wb_reg_write;
  assign wb_rd        = r_wb_rd;
  assign wb_data      = r_wb_data;
  assign mem_err      = r_mem_err;

  // Stage register, access FSM, MEM/WB register and error flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= ST_IDLE;
      r_s            <= '0;
      r_cnt          <= '0;
      r_mem_req      <= 1'b0;
      r_mem_we       <= 1'b0;
      r_mem_addr     <= '0;
      r_mem_wdata    <= '0;
      r_wb_valid     <= 1'b0;
      r_wb_reg_write <= 1'b0;
      r_wb_rd        <= '0;
      r_wb_data      <= '0;
      r_mem_err      <= 1'b0;
    end else begin
      if (!stall) begin
        r_s <= w_cap;
      end

      case (r_state)
        ST_IDLE: begin
          if (r_s.valid) begin
            r_wb_valid <= 1'b1;
            r_wb_rd    <= r_s.rd;
            if (w_s_is_mem) begin
              // Only misaligned memory ops can still sit in S while idle
              r_wb_reg_write <= 1'b0;
              r_wb_data      <= '0;
              r_mem_err      <= 1'b1;
            end else begin
              r_wb_reg_write <= r_s.reg_write;
              r_wb_data      <= r_s.result;
            end
          end else begin
            r_wb_valid <= 1'b0;
          end

          if (w_cap_mem) begin
            r_state     <= ST_ACCESS;
            r_cnt       <= '0;
            r_mem_req   <= 1'b1;
            r_mem_we    <= w_cap.mem_write;
            r_mem_addr  <= ex_result;
            r_mem_wdata <= ex_out_b;
          end
        end

        ST_ACCESS: begin
          if (!r_mem_req) begin
            // One-cycle request gap between back-to-back accesses
            r_wb_valid <= 1'b0;
            r_cnt      <= '0;
            r_mem_req  <= 1'b1;
          end else if (mem_ack) begin
            r_wb_valid <= 1'b1;
            r_wb_rd    <= r_s.rd;
            if (r_s.mem_read) begin
              r_wb_reg_write <= r_s.reg_write;
              r_wb_data      <= mem_rdata;
            end else begin
              r_wb_reg_write <= 1'b0;
              r_wb_data      <= '0;
            end
            r_mem_req <= 1'b0;
            r_cnt     <= '0;
            if (w_cap_mem) begin
              r_mem_we    <= w_cap.mem_write;
              r_mem_addr  <= ex_result;
              r_mem_wdata <= ex_out_b;
            end else begin
              r_state <= ST_IDLE;
            end
          end else if (r_cnt == CNT_LAST) begin
            // Abort: S is retired here so the dead op is not replayed when idle
            r_wb_valid     <= 1'b1;
            r_wb_reg_write <= 1'b0;
            r_wb_rd        <= r_s.rd;
            r_wb_data      <= '0;
            r_mem_err      <= 1'b1;
            r_mem_req      <= 1'b0;
            r_cnt          <= '0;
            r_s.valid      <= 1'b0;
            r_state        <= ST_IDLE;
          end else begin
            r_wb_valid <= 1'b0;
            r_cnt      <= r_cnt + CNT_W'(1);
          end
        end

        default: begin
          r_state   <= ST_IDLE;
          r_mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: a scoreboard queue of expected write-backs
// checked by a monitor, plus point checks on memory, stall, forwarding and error outputs.
module tb_mem_access_stage;

  logic        clk;
  logic        rst_n;
  logic        ex_valid;
  logic [31:0] ex_result;
  logic [31:0] ex_out_b;
  logic [3:0]  ex_rd;
  logic        ex_mem_read;
  logic        ex_mem_write;
  logic        ex_reg_write;
  logic        flush;
  logic        stall;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        wb_valid;
  logic        wb_reg_write;
  logic [3:0]  wb_rd;
  logic [31:0] wb_data;
  logic        fwd_valid;
  logic [3:0]  fwd_rd;
  logic [31:0] fwd_data;
  logic        mem_err;

  mem_access_stage #(.DATA_W(32), .REG_W(4), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid(ex_valid), .ex_result(ex_result), .ex_out_b(ex_out_b), .ex_rd(ex_rd),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_reg_write(ex_reg_write),
    .flush(flush), .stall(stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .wb_valid(wb_valid), .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data),
    .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data), .mem_err(mem_err)
  );

  typedef struct {
    logic        rw;
    logic [3:0]  rd;
    logic [31:0] data;
  } exp_t;

  exp_t        sb[$];
  int          checks   = 0;
  int          failures = 0;
  int          rsp_lat  = 0;
  logic        rsp_by_addr = 1'b0;
  logic [31:0] rsp_data = '0;
  int          n_req = 0, n_stall = 0, n_rise = 0;
  int          s_req, s_stall, s_rise;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endfunction

  // Pops one expected entry for every cycle the DUT presents a write-back
  task automatic monitor();
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (wb_valid) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL wb_unexpected: got rd=%0d data=0x%08h with nothing expected", wb_rd, wb_data);
        end else begin
          e = sb.pop_front();
          chk("wb_reg_write", 32'(wb_reg_write), 32'(e.rw));
          chk("wb_rd", 32'(wb_rd), 32'(e.rd));
          chk("wb_data", wb_data, e.data);
        end
      end
    end
  endtask

  // Acks on the rsp_lat-th cycle of a request; rsp_lat=0 never acks
  task automatic responder();
    int n = 0;
    forever begin
      @(negedge clk);
      #1;
      if (mem_req && rsp_lat > 0) begin
        n++;
        if (n == rsp_lat) begin
          mem_ack   = 1'b1;
          mem_rdata = rsp_by_addr ? {mem_addr[15:0], 16'hBEEF} : rsp_data;
        end else begin
          mem_ack   = 1'b0;
          mem_rdata = '0;
        end
      end else begin
        n         = 0;
        mem_ack   = 1'b0;
        mem_rdata = '0;
      end
    end
  endtask

  task automatic stats();
    logic prev = 1'b0;
    forever begin
      @(negedge clk);
      #4;
      if (mem_req) n_req++;
      if (stall) n_stall++;
      if (mem_req && !prev) n_rise++;
      prev = mem_req;
    end
  endtask

  task automatic snap();
    s_req   = n_req;
    s_stall = n_stall;
    s_rise  = n_rise;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(negedge clk);
      #2;
    end
  endtask

  // Presents one instruction, holds it while stalled, returns just after its capture edge
  task automatic send(input logic v, input logic fl, input logic [31:0] res, input logic [31:0] b,
                      input logic [3:0] rd, input logic rd_op, input logic wr_op, input logic rw,
                      input logic push, input logic e_rw, input logic [31:0] e_data);
    exp_t e;
    logic ok = 1'b0;
    ex_valid = v; flush = fl; ex_result = res; ex_out_b = b; ex_rd = rd;
    ex_mem_read = rd_op; ex_mem_write = wr_op; ex_reg_write = rw;
    if (push) begin
      e.rw = e_rw; e.rd = rd; e.data = e_data;
      sb.push_back(e);
    end
    for (int k = 0; k < 64; k++) begin
      #2;
      if (!stall) ok = 1'b1;
      @(negedge clk);
      #2;
      if (ok) break;
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL capture_timeout: got stall=1 for 64 cycles expected capture");
    end
    ex_valid = 1'b0; flush = 1'b0; ex_mem_read = 1'b0; ex_mem_write = 1'b0; ex_reg_write = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    ex_valid = 1'b0; ex_result = '0; ex_out_b = '0; ex_rd = '0;
    ex_mem_read = 1'b0; ex_mem_write = 1'b0; ex_reg_write = 1'b0; flush = 1'b0;
    mem_ack = 1'b0; mem_rdata = '0;
    fork
      monitor();
      responder();
      stats();
    join_none

    idle_cycles(2);
    chk("rst_mem_req", 32'(mem_req), 0);
    chk("rst_stall", 32'(stall), 0);
    chk("rst_wb_valid", 32'(wb_valid), 0);
    chk("rst_wb_data", wb_data, 0);
    chk("rst_fwd_valid", 32'(fwd_valid), 0);
    chk("rst_mem_err", 32'(mem_err), 0);
    rst_n = 1'b1;
    idle_cycles(1);

    // ALU op: forward next edge, write back one edge later, no stall
    snap();
    send(1, 0, 32'h42, 32'h0, 4'd3, 0, 0, 1, 1, 1, 32'h42);
    chk("alu_fwd_valid", 32'(fwd_valid), 1);
    chk("alu_fwd_rd", 32'(fwd_rd), 3);
    chk("alu_fwd_data", fwd_data, 32'h42);
    idle_cycles(3);
    chk("alu_stall_cycles", 32'(n_stall - s_stall), 0);

    // Load, ack on third request cycle
    rsp_lat = 3; rsp_by_addr = 1'b0; rsp_data = 32'hDEAD_BEEF;
    snap();
    send(1, 0, 32'h100, 32'h0, 4'd5, 1, 0, 1, 1, 1, 32'hDEAD_BEEF);
    chk("ld_mem_req", 32'(mem_req), 1);
    chk("ld_mem_we", 32'(mem_we), 0);
    chk("ld_mem_addr", mem_addr, 32'h100);
    chk("ld_fwd_valid", 32'(fwd_valid), 0);
    idle_cycles(5);
    chk("ld_req_cycles", 32'(n_req - s_req), 3);
    chk("ld_stall_cycles", 32'(n_stall - s_stall), 2);

    // Store immediately followed by an ALU op held by stall
    rsp_lat = 2;
    send(1, 0, 32'h204, 32'h1234, 4'd6, 0, 1, 0, 1, 0, 32'h0);
    chk("st_mem_req", 32'(mem_req), 1);
    chk("st_mem_we", 32'(mem_we), 1);
    chk("st_mem_wdata", mem_wdata, 32'h1234);
    chk("st_mem_addr", mem_addr, 32'h204);
    send(1, 0, 32'h77, 32'h0, 4'd7, 0, 0, 1, 1, 1, 32'h77);
    chk("st_next_fwd_valid", 32'(fwd_valid), 1);
    chk("st_next_fwd_data", fwd_data, 32'h77);
    chk("st_next_mem_req", 32'(mem_req), 0);
    idle_cycles(3);

    // Misaligned load
    chk("pre_mis_mem_err", 32'(mem_err), 0);
    snap();
    send(1, 0, 32'h102, 32'h0, 4'd8, 1, 0, 1, 1, 0, 32'h0);
    chk("mis_mem_req", 32'(mem_req), 0);
    idle_cycles(1);
    chk("mis_mem_err", 32'(mem_err), 1);
    chk("mis_req_cycles", 32'(n_req - s_req), 0);
    idle_cycles(2);

    // Flushed instruction leaves no write-back
    send(1, 1, 32'h99, 32'h0, 4'd9, 0, 0, 1, 0, 0, 32'h0);
    chk("flush_fwd_valid", 32'(fwd_valid), 0);
    send(1, 0, 32'h55, 32'h0, 4'd10, 0, 0, 1, 1, 1, 32'h55);
    idle_cycles(3);

    // Back-to-back loads need a request gap
    rsp_lat = 1; rsp_by_addr = 1'b1;
    snap();
    send(1, 0, 32'h500, 32'h0, 4'd1, 1, 0, 1, 1, 1, 32'h0500_BEEF);
    send(1, 0, 32'h504, 32'h0, 4'd2, 1, 0, 1, 1, 1, 32'h0504_BEEF);
    chk("b2b_gap_mem_req", 32'(mem_req), 0);
    chk("b2b_gap_mem_addr", mem_addr, 32'h504);
    idle_cycles(4);
    chk("b2b_req_cycles", 32'(n_req - s_req), 2);
    chk("b2b_req_rises", 32'(n_rise - s_rise), 2);
    chk("b2b_stall_cycles", 32'(n_stall - s_stall), 1);

    // Reset mid-access drops everything asynchronously
    rsp_lat = 0; rsp_by_addr = 1'b0;
    send(1, 0, 32'h300, 32'h0, 4'd11, 1, 0, 1, 0, 0, 32'h0);
    chk("pre_rst_mem_req", 32'(mem_req), 1);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_mem_req", 32'(mem_req), 0);
    chk("arst_stall", 32'(stall), 0);
    chk("arst_mem_err", 32'(mem_err), 0);
    chk("arst_fwd_valid", 32'(fwd_valid), 0);
    chk("arst_wb_valid", 32'(wb_valid), 0);
    idle_cycles(1);
    rst_n = 1'b1;
    idle_cycles(1);

    // Ack on the last allowed cycle wins over the timeout
    rsp_lat = 16; rsp_data = 32'h600D_F00D;
    send(1, 0, 32'h408, 32'h0, 4'd14, 1, 0, 1, 1, 1, 32'h600D_F00D);
    idle_cycles(18);
    chk("late_ack_mem_err", 32'(mem_err), 0);

    // Timeout after 16 access cycles
    rsp_lat = 0;
    snap();
    send(1, 0, 32'h400, 32'h0, 4'd12, 1, 0, 1, 1, 0, 32'h0);
    idle_cycles(15);
    chk("to_last_mem_req", 32'(mem_req), 1);
    chk("to_last_mem_err", 32'(mem_err), 0);
    idle_cycles(1);
    chk("to_mem_req", 32'(mem_req), 0);
    chk("to_mem_err", 32'(mem_err), 1);
    chk("to_stall", 32'(stall), 0);
    idle_cycles(2);
    chk("to_req_cycles", 32'(n_req - s_req), 16);
    chk("to_stall_cycles", 32'(n_stall - s_stall), 16);

    // Subsequent load completes; error stays sticky
    rsp_lat = 1; rsp_data = 32'hCAFE_F00D;
    send(1, 0, 32'h404, 32'h0, 4'd13, 1, 0, 1, 1, 1, 32'hCAFE_F00D);
    idle_cycles(3);
    chk("post_to_mem_err", 32'(mem_err), 1);

    chk("sb_drained", 32'(sb.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
